// File: rtl/relm_uart_pkg.sv
// Shared types and constants for the ReLM UART transmitter.
// Contents: FSM state encoding, data bits per frame, status word bit positions.
// Imported by the top level; the FIFO and interface are type-agnostic.
package relm_uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } state_t;

  localparam int RELM_UART_NDATA = 8;

  // Status word layout: busy flag, then the FIFO count field above it.
  localparam int STAT_BUSY      = 0;
  localparam int STAT_COUNT_LSB = 1;

endpackage

// File: rtl/relm_uart_tx_io_if.sv
// ReLM push/pop channel pair seen by the UART transmitter.
// Ports: push_d/push_retry (byte push with retry), pop_d/pop_q (status pop, drain-wait retry).
// master = PE side driving strobes, slave = device side answering.
interface relm_uart_tx_io_if #(
  parameter int WD = 32
);
  logic [WD:0] push_d;
  logic        push_retry;
  logic [WD:0] pop_d;
  logic [WD:0] pop_q;

  modport master (output push_d, output pop_d, input push_retry, input pop_q);
  modport slave  (input push_d, input pop_d, output push_retry, output pop_q);
endinterface

// File: rtl/relm_uart_tx_fifo.sv
// Single-clock byte FIFO, 2^WAD deep, with count and registered full/empty flags.
// Ports: wr_en/wr_dat in, rd_en in, rd_dat (head entry), count, full, empty out.
// Latency: a write is visible at rd_dat the cycle after it; writes when full / reads when empty are dropped.
module relm_uart_tx_fifo #(
  parameter int WAD = 4,
  parameter int W   = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         wr_en,
  input  logic [W-1:0] wr_dat,
  input  logic         rd_en,
  output logic [W-1:0] rd_dat,
  output logic [WAD:0] count,
  output logic         full,
  output logic         empty
);
  localparam int DEPTH = 2 ** WAD;
  localparam logic [WAD:0] FULL_CNT = (WAD + 1)'(DEPTH);

  logic [W-1:0]   mem [DEPTH];
  logic [WAD-1:0] wr_ptr;
  logic [WAD-1:0] rd_ptr;
  logic           do_wr;
  logic           do_rd;
  logic [WAD:0]   count_nxt;

  assign do_wr = wr_en & ~full;
  assign do_rd = rd_en & ~empty;

  always_comb begin
    count_nxt = count;
    if (do_wr && !do_rd) begin
      count_nxt = count + 1'b1;
    end else if (!do_wr && do_rd) begin
      count_nxt = count - 1'b1;
    end
  end

  // Flags are computed from the next count so they stay registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      count <= count_nxt;
      full  <= (count_nxt == FULL_CNT);
      empty <= (count_nxt == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_dat;
  end

  // Storage is a flop array, so the head byte is readable the cycle empty drops.
  assign rd_dat = mem[rd_ptr];

endmodule

// File: rtl/relm_uart_tx_io.sv
// ReLM push/pop responder: queues pushed bytes and sends them as async serial frames on tx.
// Ports: clk, rst_n, bus (slave: push_d/push_retry, pop_d/pop_q), tx (serial out, idles high).
// Latency: byte pushed into an idle core starts its start bit one cycle later; push retries while the FIFO is full, drain-wait pop retries while busy.
// Build option: RELM_UART_PARITY_EN adds an even-parity bit before stop and sets status bit WAD+2.
module relm_uart_tx_io
  import relm_uart_pkg::*;
#(
  parameter int WD   = 32,
  parameter int WAD  = 4,
  parameter int WDIV = 16,
  parameter int DIV  = 434
) (
  input  logic             clk,
  input  logic             rst_n,
  relm_uart_tx_io_if.slave bus,
  output logic             tx
);
  localparam logic [WDIV-1:0] DIV_M1   = WDIV'(DIV - 1);
  localparam logic [2:0]      LAST_BIT = 3'(RELM_UART_NDATA - 1);

  logic            fifo_wr;
  logic            fifo_rd;
  logic            fifo_full;
  logic            fifo_empty;
  logic [7:0]      fifo_rd_dat;
  logic [WAD:0]    fifo_count;

  state_t          state;
  logic [WDIV-1:0] baud;
  logic [7:0]      shift;
  logic [2:0]      bit_idx;
  logic            baud_done;
  logic            busy;
  logic [WD-1:0]   status;
  logic            unused_bits;
`ifdef RELM_UART_PARITY_EN
  logic            par;
`endif

  assign baud_done = (baud == '0);
  assign fifo_wr   = bus.push_d[WD] & ~fifo_full;
  // Dequeue from IDLE, or straight out of the last stop-bit cycle for gapless frames.
  assign fifo_rd   = ~fifo_empty & ((state == ST_IDLE) | ((state == ST_STOP) & baud_done));

  relm_uart_tx_fifo #(
    .WAD (WAD),
    .W   (8)
  ) u_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .wr_en  (fifo_wr),
    .wr_dat (bus.push_d[7:0]),
    .rd_en  (fifo_rd),
    .rd_dat (fifo_rd_dat),
    .count  (fifo_count),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      baud    <= '0;
      shift   <= '0;
      bit_idx <= '0;
      tx      <= 1'b1;
`ifdef RELM_UART_PARITY_EN
      par     <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          tx <= 1'b1;
          if (fifo_rd) begin
            state <= ST_START;
            baud  <= DIV_M1;
            shift <= fifo_rd_dat;
            tx    <= 1'b0;
`ifdef RELM_UART_PARITY_EN
            par   <= ^fifo_rd_dat;
`endif
          end
        end
        ST_START: begin
          if (baud_done) begin
            state   <= ST_DATA;
            baud    <= DIV_M1;
            bit_idx <= '0;
            tx      <= shift[0];
          end else begin
            baud <= baud - 1'b1;
          end
        end
        ST_DATA: begin
          if (baud_done) begin
            baud <= DIV_M1;
            if (bit_idx == LAST_BIT) begin
`ifdef RELM_UART_PARITY_EN
              state <= ST_PARITY;
              tx    <= par;
`else
              state <= ST_STOP;
              tx    <= 1'b1;
`endif
            end else begin
              // tx is registered, so present the next bit from shift[1] while shifting.
              bit_idx <= bit_idx + 1'b1;
              shift   <= shift >> 1;
              tx      <= shift[1];
            end
          end else begin
            baud <= baud - 1'b1;
          end
        end
`ifdef RELM_UART_PARITY_EN
        ST_PARITY: begin
          if (baud_done) begin
            state <= ST_STOP;
            baud  <= DIV_M1;
            tx    <= 1'b1;
          end else begin
            baud <= baud - 1'b1;
          end
        end
`endif
        ST_STOP: begin
          if (baud_done) begin
            if (fifo_rd) begin
              state <= ST_START;
              baud  <= DIV_M1;
              shift <= fifo_rd_dat;
              tx    <= 1'b0;
`ifdef RELM_UART_PARITY_EN
              par   <= ^fifo_rd_dat;
`endif
            end else begin
              state <= ST_IDLE;
              tx    <= 1'b1;
            end
          end else begin
            baud <= baud - 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
          tx    <= 1'b1;
        end
      endcase
    end
  end

  assign busy = ~fifo_empty | (state != ST_IDLE);

  always_comb begin
    status = '0;
    status[STAT_BUSY] = busy;
    status[STAT_COUNT_LSB +: WAD + 1] = fifo_count;
`ifdef RELM_UART_PARITY_EN
    status[WAD + 2] = 1'b1;
`endif
  end

  assign bus.push_retry = fifo_full;
  assign bus.pop_q      = {bus.pop_d[0] & busy, status};

  // Channel bits that carry no meaning for this device.
  assign unused_bits = ^{bus.push_d[WD-1:8], bus.pop_d[WD:1]};

endmodule

// File: tb/tb_relm_uart_tx_io.sv
module tb_relm_uart_tx_io;
  localparam int WD    = 32;
  localparam int WAD   = 2;
  localparam int WDIV  = 16;
  localparam int DIV   = 4;
  localparam int DEPTH = 4;
`ifdef RELM_UART_PARITY_EN
  localparam int NSLOT = 11;
  localparam logic [WD-1:0] BUILD_BIT = 32'h10;
`else
  localparam int NSLOT = 10;
  localparam logic [WD-1:0] BUILD_BIT = 32'h0;
`endif
  localparam int FLEN = NSLOT * DIV;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic tx;

  relm_uart_tx_io_if #(.WD(WD)) bus ();

  relm_uart_tx_io #(
    .WD(WD), .WAD(WAD), .WDIV(WDIV), .DIV(DIV)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .tx(tx)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model: byte queue + frame position ----------------
  logic [7:0] mq[$];
  logic [7:0] m_cur = 8'h00;
  logic       m_act = 1'b0;
  int         m_pos = 0;
  logic       m_last_acc = 1'b0;

  function automatic logic slot_bit(input logic [7:0] b, input int s);
    if (s == 0) return 1'b0;
    if (s <= 8) return b[s-1];
    if (NSLOT == 11 && s == 9) return ^b;
    return 1'b1;
  endfunction

  function automatic logic m_busy();
    return m_act || (mq.size() != 0);
  endfunction

  always @(posedge clk) begin
    logic [WD:0]   pd;
    logic [WD:0]   od;
    logic [WD-1:0] st;
    logic          bz;
    pd = bus.push_d;
    od = bus.pop_d;
    if (!rst_n) begin
      mq.delete();
      m_act = 1'b0;
      m_pos = 0;
      m_last_acc = 1'b0;
    end else begin
      m_last_acc = pd[WD] && (mq.size() < DEPTH);
      if (m_act) begin
        m_pos++;
        if (m_pos == FLEN) m_act = 1'b0;
      end
      if (!m_act && mq.size() != 0) begin
        m_cur = mq.pop_front();
        m_act = 1'b1;
        m_pos = 0;
      end
      if (m_last_acc) mq.push_back(pd[7:0]);
    end
    #1;
    bz = m_busy();
    st = BUILD_BIT;
    st[0] = bz;
    st[WAD+1:1] = (WAD + 1)'(mq.size());
    chk("model_tx", 64'(tx), 64'(m_act ? slot_bit(m_cur, m_pos / DIV) : 1'b1));
    chk("model_push_retry", 64'(bus.push_retry), 64'(mq.size() == DEPTH));
    chk("model_pop_q", 64'(bus.pop_q), 64'({od[0] & bz, st}));
  end

  // ---------------- stimulus helpers (called at a negedge) ----------------
  int dut_stall = 0;

  task automatic push_byte(input logic [7:0] b);
    int g;
    g = 0;
    bus.push_d = {1'b1, {(WD-8){1'b0}}, b};
    do begin
      if (bus.push_retry) dut_stall++;
      @(posedge clk);
      #2;
      g++;
    end while (!m_last_acc && g < 200);
    if (!m_last_acc) begin
      n_vec++;
      n_bad++;
      $display("FAIL push_timeout: byte %0h not accepted within %0d cycles", b, g);
    end
    @(negedge clk);
  endtask

  task automatic push_clear();
    bus.push_d = '0;
  endtask

  task automatic wait_idle();
    int g;
    g = 0;
    while (m_busy() && g < 3000) begin
      @(posedge clk);
      #2;
      g++;
    end
    if (m_busy()) begin
      n_vec++;
      n_bad++;
      $display("FAIL idle_timeout: still busy after %0d cycles", g);
    end
    @(negedge clk);
  endtask

  // ---------------- directed frame table ----------------
  typedef struct {
    logic [7:0] din;
    logic [9:0] frame;   // 8N1 line level per bit slot, slot 0 = start bit
    logic       par;     // expected even-parity bit
  } vec_t;

  vec_t vt[9];

  function automatic logic tab_slot(input vec_t v, input int s);
    if (s <= 8) return v.frame[s];
    if (NSLOT == 11 && s == 9) return v.par;
    return 1'b1;
  endfunction

  initial begin
    int cnt;
    vt[0] = '{8'h55, 10'b1010101010, 1'b0};
    vt[1] = '{8'hA3, 10'b1101000110, 1'b0};
    vt[2] = '{8'h0F, 10'b1000011110, 1'b0};
    vt[3] = '{8'h81, 10'b1100000010, 1'b0};
    vt[4] = '{8'h3C, 10'b1001111000, 1'b0};
    vt[5] = '{8'h07, 10'b1000001110, 1'b1};
    vt[6] = '{8'h00, 10'b1000000000, 1'b0};
    vt[7] = '{8'hFF, 10'b1111111110, 1'b0};
    vt[8] = '{8'h01, 10'b1000000010, 1'b1};

    bus.push_d = '0;
    bus.pop_d  = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state, with a drain-wait pop presented.
    bus.pop_d = {1'b1, {(WD-1){1'b0}}, 1'b1};
    #1;
    chk("rst_tx", 64'(tx), 64'(1'b1));
    chk("rst_push_retry", 64'(bus.push_retry), 64'(1'b0));
    chk("rst_pop_q", 64'(bus.pop_q), 64'({1'b0, BUILD_BIT}));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_drain_pop_q", 64'(bus.pop_q), 64'({1'b0, BUILD_BIT}));
    bus.pop_d = '0;
    @(negedge clk);

    // Single frames from the table, sampled every cycle.
    for (int i = 0; i < 9; i++) begin
      push_byte(vt[i].din);
      push_clear();
      for (int k = 0; k < FLEN; k++) begin
        @(posedge clk);
        #1;
        chk("table_tx", 64'(tx), 64'(tab_slot(vt[i], k / DIV)));
        chk("table_busy", 64'(bus.pop_q[0]), 64'(1'b1));
      end
      @(posedge clk);
      #1;
      chk("table_end_tx", 64'(tx), 64'(1'b1));
      chk("table_end_busy", 64'(bus.pop_q[0]), 64'(1'b0));
      @(negedge clk);
    end

    // Two pushes on consecutive edges: both frames abut, so busy stays up
    // from the edge after the second push through the end of frame two.
    push_byte(8'hA3);
    push_byte(8'h0F);
    push_clear();
    cnt = 0;
    for (int k = 0; k < 4 * FLEN; k++) begin
      @(posedge clk);
      #1;
      if (!bus.pop_q[0]) break;
      cnt++;
    end
    chk("b2b_busy_run", 64'(cnt), 64'(2 * FLEN - 1));
    wait_idle();

    // Six back-to-back pushes: the sixth waits until the first frame ends
    // (edge 2+FLEN), stalling on edges 6..FLEN+2.
    dut_stall = 0;
    for (int i = 0; i < 6; i++) push_byte(8'($urandom));
    push_clear();
    chk("six_push_stall", 64'(dut_stall), 64'(FLEN - 3));
    wait_idle();

    // Drain-wait pop raised ten edges into a frame retries until the stop bit ends.
    push_byte(8'h96);
    push_clear();
    repeat (9) @(negedge clk);
    bus.pop_d = {1'b1, {(WD-1){1'b0}}, 1'b1};
    cnt = 0;
    for (int k = 0; k < 4 * FLEN; k++) begin
      @(posedge clk);
      #1;
      if (!bus.pop_q[WD]) break;
      cnt++;
    end
    chk("drain_retry_cycles", 64'(cnt), 64'(FLEN - 9));
    chk("drain_status", 64'(bus.pop_q[WD-1:0]), 64'(BUILD_BIT));
    @(negedge clk);
    bus.pop_d = '0;
    wait_idle();

    // Asynchronous reset in the middle of the data bits.
    push_byte(8'h3C);
    push_clear();
    repeat (15) @(negedge clk);
    chk("pre_rst_busy", 64'(bus.pop_q[0]), 64'(1'b1));
    rst_n = 1'b0;
    #1;
    chk("async_rst_tx", 64'(tx), 64'(1'b1));
    chk("async_rst_status", 64'(bus.pop_q), 64'({1'b0, BUILD_BIT}));
    chk("async_rst_retry", 64'(bus.push_retry), 64'(1'b0));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    push_byte(8'h81);
    push_clear();
    wait_idle();

    // Randomized traffic checked by the model every cycle.
    for (int r = 0; r < 150; r++) begin
      case ($urandom_range(0, 3))
        0, 1: push_byte(8'($urandom));
        2: begin
          push_clear();
          repeat ($urandom_range(1, 20)) @(negedge clk);
        end
        default: begin
          push_clear();
          bus.pop_d = {1'b1, {(WD-1){1'b0}}, 1'($urandom)};
          repeat ($urandom_range(1, 6)) @(negedge clk);
          bus.pop_d = '0;
        end
      endcase
    end
    push_clear();
    bus.pop_d = '0;
    wait_idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
